float_addsub: RTL and testbench
===============================

FLOAT_ADDSUB -- requirements
Module: float_addsub

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width (min 3).
REQ-002 SHALL have parameter MAN_W, default 23, stored fraction width (min 2); operand width W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operands and op valid.
REQ-006 SHALL have port in_ready  output  1  block accepts an operation this cycle.
REQ-007 SHALL have port op  input  1  0 = x+y, 1 = x-y (y sign inverted before processing).
REQ-008 SHALL have ports x, y  input  W  IEEE-754-style operands {sign, exponent, fraction}.
REQ-009 SHALL have port out_valid  output  1  z/overflow valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port z  output  W  result.
REQ-012 SHALL have port overflow  output  2  00 none, 01 overflow, 10 underflow (subnormal nonzero result), 11 NaN/infinity operand.

Function
REQ-013 SHALL implement FSM IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> ROUND -> DONE -> IDLE, one state per cycle except DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE; an operation is accepted when in_valid && in_ready, and x, y, op are registered that cycle.
REQ-015 SHALL assert out_valid in DONE exactly 6 cycles after the accept edge, for every operand class including specials.
REQ-016 SHALL hold z, overflow and out_valid stable in DONE until out_valid && out_ready, then return to IDLE on the next edge (no same-cycle re-accept; throughput at most 1 op / 7 cycles).
REQ-017 UNPACK: exponent 0 with nonzero fraction is subnormal, with hidden bit 0 and effective exponent 1; otherwise hidden bit 1.
REQ-018 ALIGN: smaller-magnitude operand right-shifted by the exponent difference in one cycle into MAN_W+4 bits (hidden, fraction, guard, round, sticky); bits shifted past sticky are ORed into sticky; difference > MAN_W+3 leaves only sticky.
REQ-019 ADD: same effective signs add; different signs subtract smaller from larger magnitude, with result sign that of the larger; exact cancellation gives +0.
REQ-020 NORM: carry-out shifts right 1 (sticky preserved) and increments the exponent; otherwise left-shift by leading-zero count, limited so the exponent does not fall below 1 (result subnormal, exponent field 0).
REQ-021 ROUND: round to nearest, ties to even, using guard/round/sticky; rounding carry renormalises and increments the exponent.
REQ-022 Overflow: exponent reaching all-ones SHALL yield signed infinity (fraction 0), overflow=01.
REQ-023 Subnormal nonzero final result SHALL set overflow=10; zero result sets 00.
REQ-024 Any NaN operand, or inf - inf (effective), SHALL yield canonical NaN {0, all-ones, fraction MSB 1, rest 0}, overflow=11.
REQ-025 Otherwise, any infinite operand SHALL yield infinity with that operand's effective sign, overflow=11.
REQ-026 Zero operands SHALL pass the other operand unchanged (effective sign); +0 + -0 = +0.

Reset
REQ-027 rst=1 at a clock edge SHALL force IDLE, in_ready=1 in the following cycle, out_valid=0, z=0, overflow=00, discarding any in-flight operation.
REQ-028 rst SHALL take priority over in_valid and out_ready in the same cycle; no operation is accepted while rst=1.

Verification
REQ-029 Default params: x=0x3F800000, y=0x40000000, op=0 -> z=0x40400000, overflow=00, out_valid exactly 6 cycles after the accept edge.
REQ-030 x=0x3F800000, y=0x3F800000, op=1 -> z=0x00000000, overflow=00; x=0x7F7FFFFF, y=0x7F7FFFFF, op=0 -> z=0x7F800000, overflow=01.
REQ-031 Rounding: 0x3F800000+0x33800000 -> 0x3F800000 (tie-to-even); 0x3F800000+0x33800001 -> 0x3F800001.
REQ-032 Specials: 0x7FC00001+0x3F800000 -> 0x7FC00000, 11; 0x7F800000 with op=1 and y=0x7F800000 -> 0x7FC00000, 11; 0x00000001+0x00000001 -> 0x00000002, 10.
REQ-033 Handshake/reset: hold out_ready=0 for 10 cycles -> z stable and in_ready=0; assert rst in ALIGN -> out_valid never rises and in_ready=1 in the cycle after the rst edge.
REQ-034 EXP_W=5, MAN_W=10: 0x3C00+0x3C00 -> 0x4000, 00; 0x7BFF+0x7BFF -> 0x7C00, 01.

Source files
------------

// File: rtl/float_addsub.sv
// float_addsub: multi-cycle IEEE-754-style adder/subtractor with valid/ready handshake.
// One pipeline step per FSM state; result held in DONE until the consumer takes it.
module float_addsub #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 op,
  input  logic [EXP_W+MAN_W:0] x,
  input  logic [EXP_W+MAN_W:0] y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] z,
  output logic [1:0]           overflow
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int F  = MAN_W + 4;
  localparam int XW = (EXP_W + 1 > $clog2(F + 1)) ? EXP_W + 1 : $clog2(F + 1);
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE} state_t;
  state_t r_state, w_next;
  logic [W-1:0] r_x, r_y, r_z, r_spec_z;
  logic r_op, r_sa, r_sb, r_sign, r_spec;
  logic [1:0] r_ov;
  logic [EXP_W-1:0] r_ea, r_eb;
  logic [MAN_W:0] r_ma, r_mb;
  logic [F-1:0] r_fa, r_fb, r_m;
  logic [F:0] r_sum;
  logic [XW-1:0] r_exp;
  logic [EXP_W-1:0] w_ex, w_ey, w_eex, w_eey, w_d, w_ef;
  logic [MAN_W-1:0] w_fx, w_fy;
  logic [MAN_W:0] w_mx, w_my, w_mant;
  logic w_sy, w_nan, w_inf_x, w_inf_y, w_xbig, w_stk, w_up, w_ovf;
  logic [F-1:0] w_ext, w_sh, w_nm;
  logic [F:0] w_sum;
  logic [XW-1:0] w_lz, w_lim, w_shift, w_rexp;
  logic [MAN_W+1:0] w_rm;
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state == IDLE ? (in_valid ? UNPACK : IDLE) :
             r_state == DONE ? (out_ready ? IDLE : DONE) : state_t'(r_state + 3'd1);
  end
  always_comb begin
    in_ready  = r_state == IDLE;
    out_valid = r_state == DONE;
  end
  assign w_ex    = r_x[W-2:MAN_W];
  assign w_ey    = r_y[W-2:MAN_W];
  assign w_fx    = r_x[MAN_W-1:0];
  assign w_fy    = r_y[MAN_W-1:0];
  assign w_sy    = r_y[W-1] ^ r_op;
  assign w_eex   = (w_ex == '0) ? EXP_W'(1) : w_ex;
  assign w_eey   = (w_ey == '0) ? EXP_W'(1) : w_ey;
  assign w_mx    = {w_ex != '0, w_fx};
  assign w_my    = {w_ey != '0, w_fy};
  assign w_inf_x = (w_ex == EMAX) && (w_fx == '0);
  assign w_inf_y = (w_ey == EMAX) && (w_fy == '0);
  assign w_nan   = ((w_ex == EMAX) && (w_fx != '0)) || ((w_ey == EMAX) && (w_fy != '0)) ||
                   (w_inf_x && w_inf_y && (r_x[W-1] != w_sy));
  assign w_xbig  = {w_eex, w_mx} >= {w_eey, w_my};
  // Bits shifted out below the sticky position collapse into sticky.
  assign w_d     = r_ea - r_eb;
  assign w_ext   = {r_mb, 3'b000};
  assign w_sh    = w_ext >> w_d;
  assign w_stk   = |(w_ext & ~({F{1'b1}} << w_d));
  assign w_sum   = (r_sa == r_sb) ? {1'b0, r_fa} + {1'b0, r_fb} : {1'b0, r_fa} - {1'b0, r_fb};
  always_comb begin
    w_lz = XW'(F);
    for (int i = 0; i < F; i++) if (r_sum[i]) w_lz = XW'(F - 1 - i);
  end
  assign w_lim   = r_exp - XW'(1);
  assign w_shift = r_sum[F] ? '0 : (w_lz < w_lim) ? w_lz : w_lim;
  assign w_nm    = r_sum[F] ? {r_sum[F:2], |r_sum[1:0]} : r_sum[F-1:0] << w_shift;
  assign w_up    = r_m[2] & (r_m[1] | r_m[0] | r_m[3]);
  assign w_rm    = {1'b0, r_m[F-1:3]} + (MAN_W+2)'(w_up);
  assign w_mant  = w_rm[MAN_W+1] ? w_rm[MAN_W+1:1] : w_rm[MAN_W:0];
  assign w_rexp  = r_exp + XW'(w_rm[MAN_W+1]);
  assign w_ovf   = w_rexp >= XW'(EMAX);
  assign w_ef    = w_mant[MAN_W] ? w_rexp[EXP_W-1:0] : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_z  <= '0;
      r_ov <= 2'b00;
    end else begin
      if (r_state == IDLE && in_valid) begin
        r_x  <= x;
        r_y  <= y;
        r_op <= op;
      end
      if (r_state == UNPACK) begin
        r_sa     <= w_xbig ? r_x[W-1] : w_sy;
        r_sb     <= w_xbig ? w_sy : r_x[W-1];
        r_ea     <= w_xbig ? w_eex : w_eey;
        r_eb     <= w_xbig ? w_eey : w_eex;
        r_ma     <= w_xbig ? w_mx : w_my;
        r_mb     <= w_xbig ? w_my : w_mx;
        r_spec   <= w_nan | w_inf_x | w_inf_y;
        r_spec_z <= w_nan ? QNAN : {w_inf_x ? r_x[W-1] : w_sy, EMAX, {MAN_W{1'b0}}};
      end
      if (r_state == ALIGN) begin
        r_fa <= {r_ma, 3'b000};
        r_fb <= {w_sh[F-1:1], w_sh[0] | w_stk};
      end
      if (r_state == ADD) begin
        r_sum  <= w_sum;
        r_sign <= (r_sa != r_sb && w_sum == '0) ? 1'b0 : r_sa;
        r_exp  <= XW'(r_ea);
      end
      if (r_state == NORM) begin
        r_m   <= w_nm;
        r_exp <= r_sum[F] ? r_exp + XW'(1) : r_exp - w_shift;
      end
      if (r_state == ROUND) begin
        r_z  <= r_spec ? r_spec_z : w_ovf ? {r_sign, EMAX, {MAN_W{1'b0}}} :
                {r_sign, w_ef, w_mant[MAN_W-1:0]};
        r_ov <= r_spec ? 2'b11 : w_ovf ? 2'b01 : (w_ef == '0 && w_mant != '0) ? 2'b10 : 2'b00;
      end
    end
  end
  assign z        = r_z;
  assign overflow = r_ov;
endmodule

// File: tb/tb_float_addsub.sv
// tb_float_addsub: binary32 and binary16 instances checked against an exact-integer reference.
module tb_float_addsub;
  logic clk = 1'b0, rst;
  logic d_iv, d_ir, d_op, d_vo, d_ro;
  logic [31:0] d_x, d_y, d_z;
  logic [1:0] d_fl;
  logic h_iv, h_ir, h_op, h_vo, h_ro;
  logic [15:0] h_x, h_y, h_z;
  logic [1:0] h_fl;
  int checks = 0, failures = 0;

  float_addsub u_dut (.clk(clk), .rst(rst), .in_valid(d_iv), .in_ready(d_ir), .op(d_op),
    .x(d_x), .y(d_y), .out_valid(d_vo), .out_ready(d_ro), .z(d_z), .overflow(d_fl));
  float_addsub #(.EXP_W(5), .MAN_W(10)) u_half (.clk(clk), .rst(rst), .in_valid(h_iv),
    .in_ready(h_ir), .op(h_op), .x(h_x), .y(h_y), .out_valid(h_vo), .out_ready(h_ro),
    .z(h_z), .overflow(h_fl));

  always #5 clk = ~clk;

  // Exact reference: operands as integers in units of the smallest subnormal, one RNE rounding.
  function automatic logic [33:0] ref_add(input int ew, input int mw, input logic [31:0] a,
                                          input logic [31:0] b, input bit o);
    logic [31:0] emax, fmask, ea, eb, fa, fb, qnan;
    logic [299:0] ma, mb, sum, q, rem, half, enc, one;
    bit sa, sb, s;
    int p, sh;
    emax = (32'd1 << ew) - 1;
    fmask = (32'd1 << mw) - 1;
    sa = a[ew+mw];
    sb = b[ew+mw] ^ o;
    ea = (a >> mw) & emax;
    eb = (b >> mw) & emax;
    fa = a & fmask;
    fb = b & fmask;
    qnan = (emax << mw) | (32'd1 << (mw - 1));
    if ((ea == emax && fa != 0) || (eb == emax && fb != 0) || (ea == emax && eb == emax && sa != sb))
      return {2'b11, qnan};
    if (ea == emax) return {2'b11, (32'(sa) << (ew + mw)) | (emax << mw)};
    if (eb == emax) return {2'b11, (32'(sb) << (ew + mw)) | (emax << mw)};
    one = 1;
    ma = (ea == 0) ? 300'(fa) : 300'(fa | (32'd1 << mw)) << (ea - 1);
    mb = (eb == 0) ? 300'(fb) : 300'(fb | (32'd1 << mw)) << (eb - 1);
    if (sa == sb) begin sum = ma + mb; s = sa; end
    else if (ma >= mb) begin sum = ma - mb; s = sa; end
    else begin sum = mb - ma; s = sb; end
    if (sum == 0) return {2'b00, (sa == sb && sa) ? (32'd1 << (ew + mw)) : 32'd0};
    p = 0;
    for (int i = 0; i < 300; i++) if (sum[i]) p = i;
    if (p <= mw) enc = sum;
    else begin
      sh = p - mw;
      q = sum >> sh;
      rem = sum & ((one << sh) - 1);
      half = one << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      enc = (300'(sh) << mw) + q;
    end
    if (enc >= (300'(emax) << mw)) return {2'b01, (32'(s) << (ew + mw)) | (emax << mw)};
    return {(enc < (one << mw)) ? 2'b10 : 2'b00, (32'(s) << (ew + mw)) | enc[31:0]};
  endfunction

  function automatic logic [31:0] rnd_val(input int ew, input int mw, input int base);
    int k, e, emax;
    logic [31:0] f;
    emax = (1 << ew) - 1;
    k = $urandom_range(0, 15);
    e = base + int'($urandom_range(0, mw + 4)) - (mw + 4) / 2;
    if (e < 0) e = 0;
    if (e > emax) e = emax;
    if (k == 0) e = 0;
    else if (k == 1) e = emax;
    else if (k < 4) e = $urandom_range(0, emax);
    f = $urandom & ((32'd1 << mw) - 1);
    if ($urandom_range(0, 5) == 0) f = 0;
    return (32'($urandom_range(0, 1)) << (ew + mw)) | (32'(e) << mw) | f;
  endfunction

  // Drives one operation, returns result and the cycle (after the accept edge) where out_valid rose.
  task automatic run_op(input bit h, input logic [31:0] a, input logic [31:0] b, input bit o,
                        output logic [31:0] rz, output logic [1:0] rf, output int lat);
    bit acc = 0;
    rz = 0; rf = 0; lat = -1;
    @(negedge clk);
    if (h) begin h_x = a[15:0]; h_y = b[15:0]; h_op = o; h_iv = 1; end
    else begin d_x = a; d_y = b; d_op = o; d_iv = 1; end
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = h ? h_ir : d_ir;
      @(posedge clk);
      if (!acc) @(negedge clk);
    end
    @(negedge clk);
    d_iv = 0; h_iv = 0;
    for (int c = 1; c <= 20 && acc; c++) begin
      if (h ? h_vo : d_vo) begin
        lat = c;
        rz = h ? {16'd0, h_z} : d_z;
        rf = h ? h_fl : d_fl;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1; d_iv = 1; h_iv = 1; d_ro = 1; h_ro = 1; d_op = 0; h_op = 0;
    d_x = 32'h3F800000; d_y = 32'h3F800000; h_x = 16'h3C00; h_y = 16'h3C00;
    repeat (3) @(negedge clk);
    checks++;
    if ({d_ir, d_vo, d_z, d_fl} !== {1'b1, 1'b0, 32'd0, 2'b00}) begin
      failures++;
      $display("FAIL reset_hold: ir=%b vo=%b z=%h fl=%b, want 1 0 00000000 00", d_ir, d_vo, d_z, d_fl);
    end
    rst = 0; d_iv = 0; h_iv = 0;
    @(negedge clk);
    checks++;
    if ({d_ir, d_vo, h_ir, h_vo, h_z, h_fl} !== {1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 2'b00}) begin
      failures++;
      $display("FAIL reset_release: d ir=%b vo=%b h ir=%b vo=%b z=%h fl=%b, want 1 0 1 0 0000 00",
               d_ir, d_vo, h_ir, h_vo, h_z, h_fl);
    end
  endtask

  localparam int ND = 13;
  localparam logic [31:0] DX [ND] = '{32'h3F800000, 32'h3F800000, 32'h7F7FFFFF, 32'h3F800000,
    32'h3F800000, 32'h7FC00001, 32'h7F800000, 32'h00000001, 32'h80000000, 32'h80000000,
    32'hFF800000, 32'h3F800000, 32'h3F800000};
  localparam logic [31:0] DY [ND] = '{32'h40000000, 32'h3F800000, 32'h7F7FFFFF, 32'h33800000,
    32'h33800001, 32'h3F800000, 32'h7F800000, 32'h00000001, 32'h00000000, 32'h00000000,
    32'h3F800000, 32'h7F800000, 32'h00000000};
  localparam bit DO [ND] = '{0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0};
  localparam logic [31:0] DZ [ND] = '{32'h40400000, 32'h00000000, 32'h7F800000, 32'h3F800000,
    32'h3F800001, 32'h7FC00000, 32'h7FC00000, 32'h00000002, 32'h00000000, 32'h80000000,
    32'hFF800000, 32'hFF800000, 32'h3F800000};
  localparam logic [1:0] DF [ND] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b11, 2'b11, 2'b10,
    2'b00, 2'b00, 2'b11, 2'b11, 2'b00};

  task automatic test_directed;
    logic [31:0] rz;
    logic [1:0] rf;
    int lat;
    for (int k = 0; k < ND; k++) begin
      run_op(0, DX[k], DY[k], DO[k], rz, rf, lat);
      checks++;
      if ({rf, rz} !== {DF[k], DZ[k]} || lat != 6) begin
        failures++;
        $display("FAIL directed%0d x=%h y=%h op=%0d: got z=%h fl=%b lat=%0d, want z=%h fl=%b lat=6",
                 k, DX[k], DY[k], DO[k], rz, rf, lat, DZ[k], DF[k]);
      end
    end
  endtask

  task automatic test_half;
    logic [31:0] rz;
    logic [1:0] rf;
    int lat;
    run_op(1, 32'h3C00, 32'h3C00, 0, rz, rf, lat);
    checks++;
    if ({rf, rz} !== {2'b00, 32'h4000} || lat != 6) begin
      failures++;
      $display("FAIL half_one_plus_one: got z=%h fl=%b lat=%0d, want 00004000 00 6", rz, rf, lat);
    end
    run_op(1, 32'h7BFF, 32'h7BFF, 0, rz, rf, lat);
    checks++;
    if ({rf, rz} !== {2'b01, 32'h7C00} || lat != 6) begin
      failures++;
      $display("FAIL half_overflow: got z=%h fl=%b lat=%0d, want 00007c00 01 6", rz, rf, lat);
    end
  endtask

  task automatic test_random(input bit h, input int n);
    int ew, mw, base, lat;
    logic [31:0] a, b, rz;
    logic [1:0] rf;
    logic [33:0] er;
    bit o;
    ew = h ? 5 : 8;
    mw = h ? 10 : 23;
    for (int k = 0; k < n; k++) begin
      base = $urandom_range(1, (1 << ew) - 2);
      a = rnd_val(ew, mw, base);
      b = rnd_val(ew, mw, base);
      if ($urandom_range(0, 9) == 0) b = a;
      o = 1'($urandom_range(0, 1));
      er = ref_add(ew, mw, a, b, o);
      run_op(h, a, b, o, rz, rf, lat);
      checks++;
      if ({rf, rz} !== er || lat != 6) begin
        failures++;
        $display("FAIL random_%0d x=%h y=%h op=%0d: got z=%h fl=%b lat=%0d, want z=%h fl=%b lat=6",
                 ew, a, b, o, rz, rf, lat, er[31:0], er[33:32]);
      end
    end
  endtask

  task automatic test_handshake;
    bit acc = 0;
    bit seen = 0;
    @(negedge clk);
    d_ro = 0; d_x = 32'h3F800000; d_y = 32'h40000000; d_op = 0; d_iv = 1;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = d_ir;
      @(negedge clk);
    end
    d_iv = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      seen = d_vo;
      if (!seen) @(negedge clk);
    end
    d_x = 32'h12345678; d_iv = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({d_vo, d_ir, d_z, d_fl} !== {1'b1, 1'b0, 32'h40400000, 2'b00}) begin
        failures++;
        $display("FAIL hold_cycle%0d: vo=%b ir=%b z=%h fl=%b, want 1 0 40400000 00",
                 i, d_vo, d_ir, d_z, d_fl);
      end
    end
    d_ro = 1;
    @(negedge clk);
    d_iv = 0;
    checks++;
    if ({d_vo, d_ir} !== 2'b01) begin
      failures++;
      $display("FAIL hold_release: vo=%b ir=%b, want 0 1", d_vo, d_ir);
    end
  endtask

  task automatic test_reset_mid;
    int rises = 0;
    @(negedge clk);
    d_x = 32'h40000000; d_y = 32'h40000000; d_op = 0; d_iv = 1;
    @(negedge clk);
    d_iv = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    checks++;
    if ({d_ir, d_vo, d_z, d_fl} !== {1'b1, 1'b0, 32'd0, 2'b00}) begin
      failures++;
      $display("FAIL reset_in_align: ir=%b vo=%b z=%h fl=%b, want 1 0 00000000 00", d_ir, d_vo, d_z, d_fl);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (d_vo) rises++;
    end
    checks++;
    if (rises != 0) begin
      failures++;
      $display("FAIL reset_discard: out_valid high %0d cycles, want 0", rises);
    end
  endtask

  task automatic test_back_to_back;
    int first = -1, second = -1;
    logic [31:0] zs = 0;
    @(negedge clk);
    d_x = 32'h40000000; d_y = 32'h3F800000; d_op = 1; d_iv = 1;
    for (int t = 0; t < 20; t++) begin
      if (d_ir) begin
        if (first < 0) first = t;
        else if (second < 0) second = t;
      end
      if (d_vo) zs = d_z;
      @(negedge clk);
    end
    d_iv = 0;
    repeat (10) @(negedge clk);
    checks++;
    if (second - first != 7 || first < 0 || zs !== 32'h3F800000) begin
      failures++;
      $display("FAIL back_to_back: accept gap=%0d z=%h, want gap 7 z=3f800000", second - first, zs);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset;
    test_directed;
    test_half;
    test_handshake;
    test_reset_mid;
    test_back_to_back;
    test_random(0, 300);
    test_random(1, 150);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
